fifo_serializer: RTL and testbench

FIFO_SERIALIZER -- requirements
Module: fifo_serializer

---
 rtl/fifo_serializer_if.sv | 16 +
 rtl/fifo_serializer.sv | 114 +++++++++++
 tb/tb_fifo_serializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_serializer_if.sv
// rtl/fifo_serializer_if.sv - upstream FIFO read port and serial-line status bundle
interface fifo_serializer_if #(
  parameter int WL = 8
) ();
  logic [WL-1:0] data_pop;
  logic          empty;
  logic          enable;
  logic          pop;
  logic          tx;
  logic          busy;
  logic          frame_done;
  logic [15:0]   word_cnt;

  modport master (output data_pop, empty, enable, input pop, tx, busy, frame_done, word_cnt);
  modport slave  (input data_pop, empty, enable, output pop, tx, busy, frame_done, word_cnt);
endinterface

// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - pops words from an upstream FIFO and sends them as
// start / LSB-first data / optional even parity / stop frames on a registered line
module fifo_serializer #(
  parameter int WL           = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  fifo_serializer_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(WL - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] idx_q, idx_d;
  logic [WL-1:0] shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    word_cnt_d = word_cnt_q;

    if (state_q inside {START, DATA, PARITY, STOP}) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.enable && !bus.empty) state_d = LOAD;
      end
      LOAD: begin
        // The word is taken in the same cycle the FIFO pointer advances.
        shift_d  = bus.data_pop;
        parity_d = ^bus.data_pop;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          word_cnt_d = word_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx lines up with the bit timing.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.pop        = (state_q == LOAD);
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == STOP) && bit_end;
  assign bus.tx         = tx_q;
  assign bus.word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_fifo_serializer.sv
// tb/tb_fifo_serializer.sv - directed scoreboard bench for fifo_serializer
module tb_fifo_serializer;
  localparam int CPB = 4;
  localparam int NB  = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_serializer_if #(.WL(8)) bus ();
  fifo_serializer_if #(.WL(8)) bus0 ();

  fifo_serializer #(.WL(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  fifo_serializer #(.WL(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int pop_count = 0;
  int pop_cyc = 0;
  int exp_wc = 0;
  logic do_pop = 1'b0;
  logic [7:0] fifo_q[$];
  logic exp_bits[$];
  logic exp0[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
    exp_bits.push_back(^w);
    exp_bits.push_back(1'b1);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    do_pop = (bus.pop === 1'b1);
    if (bus.pop === 1'b1) pop_count++;
  end

  // Upstream FIFO model: head word shown on data_pop, advanced after a pop cycle.
  initial begin
    bus.empty = 1'b1;
    bus.data_pop = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      bus.empty = (fifo_q.size() == 0);
      bus.data_pop = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    end
  end

  // act: 0 none, 1 drop enable, 2 assert reset -- applied in frame bit act_bit
  task automatic run_frame(input int act_bit, input int act);
    int waited;
    int fd;
    logic eb;
    waited = 0;
    fd = 0;
    while (bus.pop !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("pop_pulse", 32'(bus.pop), 32'd1);
    if (bus.pop !== 1'b1) return;
    pop_cyc = cyc;
    chk("load_tx", 32'(bus.tx), 32'd1);
    chk("load_busy", 32'(bus.busy), 32'd1);
    for (int b = 0; b < NB; b++) begin
      eb = exp_bits.pop_front();
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (act == 2 && b == act_bit && c == 1) begin
          #3 rst = 1'b0;
          #1;
          chk("rst_mid_tx", 32'(bus.tx), 32'd1);
          chk("rst_mid_busy", 32'(bus.busy), 32'd0);
          chk("rst_mid_done", 32'(bus.frame_done), 32'd0);
          chk("rst_mid_wc", 32'(bus.word_cnt), 32'd0);
          exp_bits.delete();
          exp_wc = 0;
          return;
        end
        if (act == 1 && b == act_bit && c == 1) bus.enable = 1'b0;
        chk($sformatf("tx_bit%0d", b), 32'(bus.tx), 32'(eb));
        if (bus.frame_done === 1'b1) fd++;
        if (b == NB - 1 && c == CPB - 1) chk("done_last", 32'(bus.frame_done), 32'd1);
      end
    end
    chk("done_count", 32'(fd), 32'd1);
    exp_wc++;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_tx", 32'(bus.tx), 32'd1);
  endtask

  initial begin
    int p0;
    int nbusy;
    int ntx;
    int t0;
    int waited;
    int fd;
    logic eb;
    logic [7:0] w0;

    rst = 1'b1;
    bus.enable = 1'b0;
    bus0.enable = 1'b0;
    bus0.empty = 1'b1;
    bus0.data_pop = 8'h00;
    #1 rst = 1'b0;
    #1;
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pop", 32'(bus.pop), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_wc", 32'(bus.word_cnt), 32'd0);
    chk("rst_tx0", 32'(bus0.tx), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Enabled but empty: nothing may happen.
    bus.enable = 1'b1;
    p0 = pop_count;
    nbusy = 0;
    ntx = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) nbusy++;
      if (bus.tx !== 1'b1) ntx++;
    end
    chk("empty_pops", 32'(pop_count - p0), 32'd0);
    chk("empty_busy", 32'(nbusy), 32'd0);
    chk("empty_tx", 32'(ntx), 32'd0);

    push_word(8'hA5);
    run_frame(-1, 0);
    chk("wc_a5", 32'(bus.word_cnt), 32'(exp_wc));

    push_word(8'h01);
    push_word(8'hFF);
    run_frame(-1, 0);
    t0 = pop_cyc;
    run_frame(-1, 0);
    chk("pop_spacing", 32'(pop_cyc - t0), 32'd46);
    chk("wc_b2b", 32'(bus.word_cnt), 32'(exp_wc));

    // Enable dropped mid-frame with a second word waiting.
    push_word(8'h3C);
    push_word(8'h55);
    run_frame(4, 1);
    p0 = pop_count;
    nbusy = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) nbusy++;
    end
    chk("noen_pops", 32'(pop_count - p0), 32'd0);
    chk("noen_busy", 32'(nbusy), 32'd0);
    chk("wc_noen", 32'(bus.word_cnt), 32'(exp_wc));
    bus.enable = 1'b1;
    run_frame(-1, 0);
    chk("wc_resume", 32'(bus.word_cnt), 32'(exp_wc));

    // Reset in the middle of data bit 5.
    push_word(8'h96);
    run_frame(6, 2);
    repeat (2) @(negedge clk);
    p0 = pop_count;
    rst = 1'b1;
    nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) nbusy++;
    end
    chk("postrst_pops", 32'(pop_count - p0), 32'd0);
    chk("postrst_busy", 32'(nbusy), 32'd0);
    push_word(8'h5A);
    run_frame(-1, 0);
    chk("wc_postrst", 32'(bus.word_cnt), 32'(exp_wc));

    // No-parity instance: 0x80 frame with the frame counter sitting at 0xFFFF.
    force dut0.word_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut0.word_cnt_q;
    w0 = 8'h80;
    exp0.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp0.push_back(w0[i]);
    exp0.push_back(1'b1);
    bus0.data_pop = w0;
    bus0.empty = 1'b0;
    bus0.enable = 1'b1;
    waited = 0;
    while (bus0.pop !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("p0_pop", 32'(bus0.pop), 32'd1);
    bus0.empty = 1'b1;
    @(posedge clk);
    #1 bus0.data_pop = 8'hFF;
    fd = 0;
    for (int b = 0; b < 10; b++) begin
      eb = exp0.pop_front();
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        chk($sformatf("p0_tx_bit%0d", b), 32'(bus0.tx), 32'(eb));
        if (bus0.frame_done === 1'b1) fd++;
      end
    end
    chk("p0_done_count", 32'(fd), 32'd1);
    @(negedge clk);
    chk("p0_wc_wrap", 32'(bus0.word_cnt), 32'd0);
    chk("p0_idle_busy", 32'(bus0.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
